// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM encoding and counter-width helper for the streaming GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} gcd_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational Stein reduction step (common shift first, then equal/even/subtract rules).
module gcd_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic             eq,
    output logic             both_even
);

    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] b_minus_a;
    logic             a_gt_b;

    assign eq        = a == b;
    assign both_even = ~a[0] & ~b[0];
    assign a_gt_b    = a > b;
    assign a_minus_b = a - b;
    assign b_minus_a = b - a;

    // Both-even only occurs during SHIFT; REDUCE always keeps one operand odd.
    assign next_a = both_even ? a >> 1 :
                    eq        ? a :
                    !a[0]     ? a >> 1 :
                    !b[0]     ? a :
                    a_gt_b    ? a_minus_b >> 1 : a;

    assign next_b = both_even ? b >> 1 :
                    eq        ? b :
                    !a[0]     ? b :
                    !b[0]     ? b >> 1 :
                    a_gt_b    ? b : b_minus_a >> 1;

endmodule

// File: rtl/gcd_stream.sv
// gcd_stream: streaming binary-GCD unit with valid/ready handshakes on both sides.
// Optional GCD_STEP_COUNT_EN adds a saturating per-result busy-cycle counter on port steps.
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             busy
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [2*CNT_W+1:0] steps
`endif
);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [WIDTH-1:0] next_a, next_b;
    logic             eq, both_even, accept, zero_in;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a         (a_q),
        .b         (b_q),
        .next_a    (next_a),
        .next_b    (next_b),
        .eq        (eq),
        .both_even (both_even)
    );

    assign accept  = state_q == IDLE && in_valid;
    assign zero_in = data_a == '0 || data_b == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            gcd_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            gcd_q   <= gcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (in_valid) state_d = zero_in ? DONE : SHIFT;
            SHIFT:  if (!both_even) state_d = REDUCE;
            REDUCE: if (eq) state_d = DONE;
            DONE:   if (out_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        k_d   = k_q;
        gcd_d = gcd_q;
        if (accept) begin
            a_d   = data_a;
            b_d   = data_b;
            k_d   = '0;
            gcd_d = zero_in ? data_a | data_b : gcd_q;
        end
        if (state_q == SHIFT && both_even) begin
            a_d = next_a;
            b_d = next_b;
            k_d = k_q + 1'b1;
        end
        if (state_q == REDUCE) begin
            a_d   = next_a;
            b_d   = next_b;
            gcd_d = eq ? a_q << k_q : gcd_q;
        end
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q == SHIFT || state_q == REDUCE;
        gcd       = gcd_q;
    end

`ifdef GCD_STEP_COUNT_EN
    logic [2*CNT_W+1:0] steps_q, steps_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) steps_q <= '0;
        else     steps_q <= steps_d;
    end

    always_comb begin
        steps_d = accept ? '0 : (busy && !(&steps_q)) ? steps_q + 1'b1 : steps_q;
        steps   = steps_q;
    end
`endif

endmodule
